// File: rtl/lcd_delay_scheduler_pkg.sv
// Shared timing definitions for the LCD delay scheduler: default clock rate,
// FSM state encodings and a width helper.
package lcd_delay_scheduler_pkg;

    localparam int unsigned CLK_HZ_DEF = 50_000_000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < v) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/lcd_delay_scheduler_rr_arb2.sv
// Two-way round-robin pick: the requester that did not own the counter last
// wins a tie; a sole requester always wins. Purely combinational.
module lcd_delay_scheduler_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win_c
);

    always_comb begin
        win_c = 2'b00;
        unique case (req)
            2'b01:   win_c = 2'b01;
            2'b10:   win_c = 2'b10;
            2'b11:   win_c = last ? 2'b01 : 2'b10;
            default: win_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/lcd_delay_scheduler.sv
// Shared microsecond delay counter for the LCD init sequencer (req0) and the
// refresh/write FSM (req1), with round-robin ownership and a done pulse.
module lcd_delay_scheduler
    import lcd_delay_scheduler_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
    parameter int unsigned TICK_HZ = 1_000_000,
    parameter int unsigned DLY_W   = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [DLY_W-1:0] dly0,
    input  logic [DLY_W-1:0] dly1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             unit_tk
);

    localparam int unsigned      PRE      = CLK_HZ / TICK_HZ;
    localparam int unsigned      PRE_W    = clog2_min1(PRE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE - 1);

    if (PRE < 1) begin : g_pre_check
        $error("lcd_delay_scheduler: CLK_HZ/TICK_HZ must be at least 1");
    end

    logic [1:0]       state, state_nxt;
    logic [1:0]       gnt_nxt, done_nxt, win;
    logic             busy_nxt, tk_nxt;
    logic             last, last_nxt;
    logic [DLY_W-1:0] remain, remain_nxt;
    logic [PRE_W-1:0] pre, pre_nxt;

    lcd_delay_scheduler_rr_arb2 u_arb (
        .req   (req),
        .last  (last),
        .win_c (win)
    );

    // Next-state and next-output logic; 'last' doubles as the current owner index.
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        done_nxt   = 2'b00;
        tk_nxt     = 1'b0;
        last_nxt   = last;
        remain_nxt = remain;
        pre_nxt    = pre;

        unique case (state)
            S_IDLE: begin
                if (|req) begin
                    state_nxt  = S_LOAD;
                    gnt_nxt    = win;
                    last_nxt   = win[1];
                    remain_nxt = win[1] ? dly1 : dly0;
                    pre_nxt    = '0;
                end
            end
            S_LOAD: begin
                if (!req[last]) begin
                    state_nxt = S_IDLE;
                    gnt_nxt   = 2'b00;
                end else if (remain == '0) begin
                    state_nxt = S_DONE;
                    done_nxt  = gnt;
                end else begin
                    state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!req[last]) begin
                    state_nxt = S_IDLE;
                    gnt_nxt   = 2'b00;
                end else if (pre == PRE_LAST) begin
                    pre_nxt = '0;
                    tk_nxt  = 1'b1;
                    if (remain != '0) begin
                        remain_nxt = remain - DLY_W'(1);
                    end
                    if (remain <= DLY_W'(1)) begin
                        state_nxt = S_DONE;
                        done_nxt  = gnt;
                    end
                end else begin
                    pre_nxt = pre + PRE_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                gnt_nxt   = 2'b00;
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = 2'b00;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            gnt     <= 2'b00;
            done    <= 2'b00;
            busy    <= 1'b0;
            unit_tk <= 1'b0;
            last    <= 1'b1;
            remain  <= '0;
            pre     <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            done    <= done_nxt;
            busy    <= busy_nxt;
            unit_tk <= tk_nxt;
            last    <= last_nxt;
            remain  <= remain_nxt;
            pre     <= pre_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_delay_scheduler.sv
// Scoreboard bench for lcd_delay_scheduler with PRE=10, DLY_W=8.
module tb_lcd_delay_scheduler;

    localparam int unsigned DLY_W = 8;

    logic             clk, rst;
    logic [1:0]       req;
    logic [DLY_W-1:0] dly0, dly1;
    logic [1:0]       gnt, done;
    logic             busy, unit_tk;

    lcd_delay_scheduler #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .DLY_W   (DLY_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .dly0    (dly0),
        .dly1    (dly1),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .unit_tk (unit_tk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] oh;
        int         at;
    } exp_t;
    exp_t sb[$];
    exp_t me;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected owner and cycle.
    always @(negedge clk) begin
        if (!rst && done != 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_done", int'(done), 0);
            end else begin
                me = sb.pop_front();
                check("done_owner", int'(done), int'(me.oh));
                check("done_cycle", cyc, me.at);
            end
        end
    end

    task automatic wait_gnt(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                at = cyc;
                return;
            end
        end
        check("gnt_timeout", 1, 0);
    endtask

    task automatic wait_done(input int limit, output int tks);
        tks = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (unit_tk) tks++;
            if (done != 2'b00) return;
        end
        check("done_timeout", 1, 0);
    endtask

    // One complete transaction for a single requester; d_after is driven after grant.
    task automatic serve(input int idx, input int d, input int d_after,
                         input int exp_tk, output int g);
        int tks;
        logic [1:0] oh;
        oh = (idx == 0) ? 2'b01 : 2'b10;
        if (idx == 0) dly0 = DLY_W'(d); else dly1 = DLY_W'(d);
        req = oh;
        wait_gnt(5, g);
        check("gnt_owner", int'(gnt), int'(oh));
        sb.push_back('{oh: oh, at: g + 1 + d * 10});
        if (idx == 0) dly0 = DLY_W'(d_after); else dly1 = DLY_W'(d_after);
        wait_done(d * 10 + 20, tks);
        check("unit_tk_count", tks, exp_tk);
        req = 2'b00;
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
    endtask

    int g, g2, tks, prev_done;

    initial begin
        rst  = 1'b1;
        req  = 2'b00;
        dly0 = '0;
        dly1 = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_unit_tk", int'(unit_tk), 0);
        rst = 1'b0;

        serve(0, 3, 3, 3, g);
        serve(0, 0, 0, 0, g);

        // Abort of requester 1 mid-count, then requester 0 granted straight away.
        dly1 = DLY_W'(5);
        req  = 2'b10;
        wait_gnt(5, g);
        check("abort_gnt", int'(gnt), 2);
        repeat (20) @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        check("abort_gnt_clear", int'(gnt), 0);
        check("abort_busy", int'(busy), 0);
        serve(0, 2, 2, 2, g2);
        check("grant_after_abort", g2, g + 22);

        // Maximum delay; a late dly change must be ignored.
        serve(0, 255, 1, 255, g);

        // Asynchronous reset mid-count drops everything.
        dly0 = DLY_W'(5);
        req  = 2'b01;
        wait_gnt(5, g);
        check("pre_rst_gnt", int'(gnt), 1);
        repeat (13) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gnt", int'(gnt), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_unit_tk", int'(unit_tk), 0);
        sb.delete();
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Both held: strict alternation starting with requester 0.
        dly0 = DLY_W'(1);
        dly1 = DLY_W'(1);
        req  = 2'b11;
        prev_done = -1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] oh;
            oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_gnt(30, g);
            check("alt_owner", int'(gnt), int'(oh));
            if (k > 0) check("alt_gap", g, prev_done + 2);
            sb.push_back('{oh: oh, at: g + 11});
            wait_done(30, tks);
            prev_done = cyc;
            if (k == 3) req = 2'b00;
        end
        @(negedge clk);
        check("alt_busy_end", int'(busy), 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
